iigs_memctl: RTL

IIGS_MEMCTL -- requirements
Module: iigs_memctl

---
 rtl/iigs_memctl_if.sv | 21 ++
 rtl/iigs_memctl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/iigs_memctl_if.sv
// CPU-side request/response bundle of the IIgs memory controller.
// The CPU side drives a request and waits for the one-cycle cpu_ready pulse.
interface iigs_memctl_if;
    logic [7:0]  cpu_bank;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_we;
    logic        cpu_valid;
    logic        cpu_ready;
    logic [7:0]  cpu_rdata;

    modport master (
        output cpu_bank, cpu_addr, cpu_wdata, cpu_we, cpu_valid,
        input  cpu_ready, cpu_rdata
    );

    modport slave (
        input  cpu_bank, cpu_addr, cpu_wdata, cpu_we, cpu_valid,
        output cpu_ready, cpu_rdata
    );
endinterface

// File: rtl/iigs_memctl.sv
// IIgs memory controller: decodes a CPU access to fast RAM, slow (E0/E1) RAM,
// ROM or slot space, sequences the strobes and mirrors video writes to slow RAM.
module iigs_memctl #(
    parameter int RAMSIZE   = 16,
    parameter int SLOW_DIV  = 2,
    parameter int SHADOW_EN = 1
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    iigs_memctl_if.slave cpu,
    input  logic [7:0]  SLTROMSEL,
    input  logic [7:0]  SHADOW,
    output logic        fast_ce,
    output logic        fast_we,
    output logic [22:0] fast_addr,
    input  logic [7:0]  fast_q,
    output logic        slow_ce,
    output logic        slow_we,
    output logic [16:0] slow_addr,
    input  logic [7:0]  slow_q,
    output logic        rom1_ce,
    output logic        rom2_ce,
    output logic [15:0] rom_addr,
    input  logic [7:0]  rom1_q,
    input  logic [7:0]  rom2_q,
    output logic        slot_ce,
    input  logic [7:0]  slot_q,
    output logic [7:0]  mem_wdata
);

    typedef enum logic [2:0] {ST_IDLE, ST_FAST, ST_SLOW, ST_SHADOW, ST_DONE} state_t;
    typedef enum logic [2:0] {TG_NONE, TG_ROM1, TG_ROM2, TG_SLOT, TG_FAST, TG_SLOW} target_t;

    localparam logic [7:0] RAM_BANKS = 8'(RAMSIZE);
    localparam logic [3:0] SLOW_LAST = 4'(SLOW_DIV - 1);

    function automatic target_t decode(input logic [7:0] bank, input logic [15:0] addr,
                                       input logic [7:0] sltromsel);
        target_t t;
        if (bank == 8'hFE) begin
            t = TG_ROM1;
        end else if (bank == 8'hFF) begin
            t = TG_ROM2;
        end else if (bank == 8'h00 && addr >= 16'hC100 && addr <= 16'hC7FF && sltromsel[addr[10:8]]) begin
            t = TG_SLOT;
        end else if (bank == 8'h00 && addr >= 16'hC100) begin
            t = TG_ROM2;
        end else if (bank < RAM_BANKS) begin
            t = TG_FAST;
        end else if (bank == 8'hE0 || bank == 8'hE1) begin
            t = TG_SLOW;
        end else begin
            t = TG_NONE;
        end
        return t;
    endfunction

    // Text/hires/super-hires pages of banks 00/01 get mirrored into E0/E1.
    function automatic logic shadow_needed(input logic [7:0] bank, input logic [15:0] addr,
                                           input logic we, input target_t tgt,
                                           input logic [3:0] inhibit);
        logic hit;
        hit = ((addr >= 16'h0400 && addr <= 16'h07FF) && !inhibit[0]) ||
              ((addr >= 16'h2000 && addr <= 16'h3FFF) && !inhibit[1]) ||
              ((addr >= 16'h4000 && addr <= 16'h5FFF) && !inhibit[2]) ||
              ((bank == 8'h01) && (addr >= 16'h2000 && addr <= 16'h9FFF) && !inhibit[3]);
        return (SHADOW_EN != 0) && we && (tgt == TG_FAST) &&
               (bank == 8'h00 || bank == 8'h01) && hit;
    endfunction

    state_t      state_r, state_next_s;
    target_t     target_r, target_s;
    logic [3:0]  cnt_r, cnt_next_s;
    logic [6:0]  bank_r;
    logic [15:0] addr_r;
    logic [7:0]  wdata_r;
    logic        we_r, we_s;
    logic        shadow_r, shadow_s;
    logic        accept_s;
    logic        fast_ce_r, fast_we_r, slow_ce_r, slow_we_r;
    logic        rom1_ce_r, rom2_ce_r, slot_ce_r;
    logic        fast_ce_s, fast_we_s, slow_ce_s, slow_we_s;
    logic        rom1_ce_s, rom2_ce_s, slot_ce_s;
    logic        ready_r;
    logic [7:0]  rdata_r, sel_q_s, rdata_next_s;
    logic        finish_s;
    logic        unused_s;

    assign unused_s = &{1'b0, SHADOW[7:4]};

    // Next-state logic; in IDLE the decode is taken from the live request.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        target_s     = target_r;
        we_s         = we_r;
        shadow_s     = shadow_r;
        accept_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cpu.cpu_valid) begin
                    accept_s = 1'b1;
                    target_s = decode(cpu.cpu_bank, cpu.cpu_addr, SLTROMSEL);
                    we_s     = cpu.cpu_we;
                    shadow_s = shadow_needed(cpu.cpu_bank, cpu.cpu_addr, cpu.cpu_we,
                                             target_s, SHADOW[3:0]);
                    if (target_s == TG_SLOW) begin
                        state_next_s = ST_SLOW;
                        cnt_next_s   = SLOW_LAST;
                    end else begin
                        state_next_s = ST_FAST;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_FAST: begin
                if (shadow_r) begin
                    state_next_s = ST_SHADOW;
                    cnt_next_s   = SLOW_LAST;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            ST_SLOW, ST_SHADOW: begin
                if (cnt_r == 4'd0) begin
                    state_next_s = ST_DONE;
                end else begin
                    cnt_next_s = cnt_r - 4'd1;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
                cnt_next_s   = 4'd0;
            end
        endcase
    end

    // Strobes for the coming cycle, registered so the outputs are glitch-free.
    always_comb begin
        fast_ce_s = 1'b0;
        fast_we_s = 1'b0;
        slow_ce_s = 1'b0;
        slow_we_s = 1'b0;
        rom1_ce_s = 1'b0;
        rom2_ce_s = 1'b0;
        slot_ce_s = 1'b0;
        case (state_next_s)
            ST_FAST: begin
                case (target_s)
                    TG_FAST: begin
                        fast_ce_s = 1'b1;
                        fast_we_s = we_s;
                    end
                    TG_ROM1: rom1_ce_s = 1'b1;
                    TG_ROM2: rom2_ce_s = 1'b1;
                    TG_SLOT: slot_ce_s = 1'b1;
                    default: fast_ce_s = 1'b0;
                endcase
            end
            ST_SLOW: begin
                slow_ce_s = 1'b1;
                slow_we_s = we_s;
            end
            ST_SHADOW: begin
                slow_ce_s = 1'b1;
                slow_we_s = 1'b1;
            end
            default: slow_ce_s = 1'b0;
        endcase
    end

    // Read-data mux; writes and unmapped reads return FF.
    always_comb begin
        case (target_r)
            TG_FAST: sel_q_s = fast_q;
            TG_SLOW: sel_q_s = slow_q;
            TG_ROM1: sel_q_s = rom1_q;
            TG_ROM2: sel_q_s = rom2_q;
            TG_SLOT: sel_q_s = slot_q;
            default: sel_q_s = 8'hFF;
        endcase
        if (we_r) begin
            rdata_next_s = 8'hFF;
        end else begin
            rdata_next_s = sel_q_s;
        end
        finish_s = (state_r != ST_DONE) && (state_next_s == ST_DONE);
    end

    // Control state, strobes and response registers.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 4'd0;
            fast_ce_r <= 1'b0;
            fast_we_r <= 1'b0;
            slow_ce_r <= 1'b0;
            slow_we_r <= 1'b0;
            rom1_ce_r <= 1'b0;
            rom2_ce_r <= 1'b0;
            slot_ce_r <= 1'b0;
            ready_r   <= 1'b0;
            rdata_r   <= 8'hFF;
        end else begin
            state_r   <= state_next_s;
            cnt_r     <= cnt_next_s;
            fast_ce_r <= fast_ce_s;
            fast_we_r <= fast_we_s;
            slow_ce_r <= slow_ce_s;
            slow_we_r <= slow_we_s;
            rom1_ce_r <= rom1_ce_s;
            rom2_ce_r <= rom2_ce_s;
            slot_ce_r <= slot_ce_s;
            ready_r   <= (state_next_s == ST_DONE);
            if (finish_s) begin
                rdata_r <= rdata_next_s;
            end
        end
    end

    // Request latch: later changes of SLTROMSEL/SHADOW cannot touch this access.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            target_r <= TG_NONE;
            bank_r   <= 7'd0;
            addr_r   <= 16'd0;
            wdata_r  <= 8'd0;
            we_r     <= 1'b0;
            shadow_r <= 1'b0;
        end else if (accept_s) begin
            target_r <= target_s;
            bank_r   <= cpu.cpu_bank[6:0];
            addr_r   <= cpu.cpu_addr;
            wdata_r  <= cpu.cpu_wdata;
            we_r     <= we_s;
            shadow_r <= shadow_s;
        end
    end

    assign fast_ce       = fast_ce_r;
    assign fast_we       = fast_we_r;
    assign fast_addr     = {bank_r, addr_r};
    assign slow_ce       = slow_ce_r;
    assign slow_we       = slow_we_r;
    assign slow_addr     = {bank_r[0], addr_r};
    assign rom1_ce       = rom1_ce_r;
    assign rom2_ce       = rom2_ce_r;
    assign slot_ce       = slot_ce_r;
    assign rom_addr      = addr_r;
    assign mem_wdata     = wdata_r;
    assign cpu.cpu_ready = ready_r;
    assign cpu.cpu_rdata = rdata_r;

endmodule
